// File: rtl/seq_logic_unit.sv
// seq_logic_unit: multi-cycle bitwise logic unit.
// Latches two WIDTH-bit operands and an op code, then evaluates one
// SLICE-bit group per cycle (LSB group first) through a single shared
// SLICE-wide gate array.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   start        - operation request, sampled only in IDLE
//   op           - 00 AND, 01 OR, 10 NOR, 11 XOR
//   a, b         - WIDTH-bit operands, latched on accepted start
//   busy         - high while slices are being evaluated
//   done         - one-cycle completion pulse; res/zero valid
//   res          - result register
//   zero         - registered res == 0 flag, updated on completion
module seq_logic_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res,
   output logic             zero
);

   localparam int unsigned N     = WIDTH / SLICE;
   localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

   generate
      if ((SLICE == 0) || ((WIDTH % SLICE) != 0)) begin : g_bad_param
         $error("seq_logic_unit: WIDTH must be a positive multiple of SLICE");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               zero_q, zero_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               last_slice_c;

   // Shared SLICE-wide gate array
   function automatic logic [SLICE-1:0] gate_f(input logic [1:0]       f_op,
                                               input logic [SLICE-1:0] x,
                                               input logic [SLICE-1:0] y);
      logic [SLICE-1:0] r;
      case (f_op)
         2'b00:   r = x & y;
         2'b01:   r = x | y;
         2'b10:   r = ~(x | y);
         default: r = x ^ y;
      endcase
      return r;
   endfunction

   assign last_slice_c = (cnt_q == CNT_W'(N - 1));

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_slice_c) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and registered-output next values
   always_comb begin
      cnt_d  = cnt_q;
      a_d    = a_q;
      b_d    = b_q;
      op_d   = op_q;
      res_d  = res_q;
      zero_d = zero_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d   = a;
               b_d   = b;
               op_d  = op;
               res_d = '0;
               cnt_d = '0;
            end
         end
         RUN: begin
            // Constant-index slice select keeps the mux explicit per group
            for (int unsigned i = 0; i < N; i++) begin
               if (cnt_q == CNT_W'(i)) begin
                  res_d[i*SLICE +: SLICE] = gate_f(op_q, a_q[i*SLICE +: SLICE],
                                                   b_q[i*SLICE +: SLICE]);
               end
            end
            if (last_slice_c) begin
               cnt_d  = '0;
               zero_d = (res_d == '0);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   assign busy = busy_q;
   assign done = done_q;
   assign res  = res_q;
   assign zero = zero_q;

endmodule
